// File: rtl/serial_add_pkg.sv
// ============================================================================
// Module   : serial_add_pkg
// Brief    : Shared state encoding and defaults for the bit-serial adder.
// Revision : 1.0
// ============================================================================
`default_nettype none

package serial_add_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int WIDTH_DEF = 4;
    localparam int CNT_W_DEF = 4;

endpackage

`default_nettype wire

// File: rtl/full_adder_bit.sv
// ============================================================================
// Module   : full_adder_bit
// Brief    : 1-bit full adder built from two half adders and an OR gate.
// Revision : 1.0
// ============================================================================
`default_nettype none

module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic w_hs1;
    logic w_hc1;
    logic w_hc2;

    xor u_x1 (w_hs1, a, b);
    and u_a1 (w_hc1, a, b);
    xor u_x2 (s, w_hs1, cin);
    and u_a2 (w_hc2, w_hs1, cin);
    or  u_o1 (cout, w_hc1, w_hc2);

endmodule

`default_nettype wire

// File: rtl/serial_add_ctrl.sv
// ============================================================================
// Module   : serial_add_ctrl
// Brief    : Sequences one full-adder cell across WIDTH bits, LSB first, and
//            holds the registered result for the display path.
// Revision : 1.0
// ============================================================================
`default_nettype none

module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam logic [CNT_W-1:0] c_last_bit = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_s_sr;
    logic             r_c;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry_out;
    logic             w_fa_s;
    logic             w_fa_c;
    logic             w_last;

    full_adder_bit u_fa (
        .a    (r_a_sr[0]),
        .b    (r_b_sr[0]),
        .cin  (r_c),
        .s    (w_fa_s),
        .cout (w_fa_c)
    );

    assign w_last = (r_cnt == c_last_bit);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (start)  w_next_state = ST_RUN;
            ST_RUN:  if (w_last) w_next_state = ST_DONE;
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == ST_RUN);
        done = (r_state == ST_DONE);
    end

    // Result registers only move on the final RUN edge, so the display
    // keeps the previous answer while the next one is being computed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a_sr      <= '0;
            r_b_sr      <= '0;
            r_s_sr      <= '0;
            r_c         <= 1'b0;
            r_cnt       <= '0;
            r_sum       <= '0;
            r_carry_out <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a_sr <= op_a;
                        r_b_sr <= op_b;
                        r_c    <= 1'b0;
                        r_cnt  <= '0;
                    end
                end
                ST_RUN: begin
                    r_a_sr <= {1'b0, r_a_sr[WIDTH-1:1]};
                    r_b_sr <= {1'b0, r_b_sr[WIDTH-1:1]};
                    r_s_sr <= {w_fa_s, r_s_sr[WIDTH-1:1]};
                    r_c    <= w_fa_c;
                    r_cnt  <= r_cnt + c_cnt_one;
                    if (w_last) begin
                        r_sum       <= {w_fa_s, r_s_sr[WIDTH-1:1]};
                        r_carry_out <= w_fa_c;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum       = r_sum;
    assign carry_out = r_carry_out;

endmodule

`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
// ============================================================================
// Module   : tb_serial_add_ctrl
// Brief    : Directed self-checking bench for serial_add_ctrl, WIDTH=4.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_serial_add_ctrl;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry_out;

    int r_checks = 0;
    int r_errors = 0;

    serial_add_ctrl #(.WIDTH(WIDTH), .CNT_W(4)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op_a      (op_a),
        .op_b      (op_b),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .carry_out (carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int actual, input int expected);
        r_checks++;
        if (actual !== expected) begin
            r_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input int eb, input int ed,
                             input int es, input int ec);
        check({tag, ".busy"},  int'(busy),      eb);
        check({tag, ".done"},  int'(done),      ed);
        check({tag, ".sum"},   int'(sum),       es);
        check({tag, ".carry"}, int'(carry_out), ec);
    endtask

    // One full operation; operands are scrambled during RUN and the prior
    // result must stay visible until the DONE edge.
    task automatic run_op(input string tag, input int a, input int b,
                          input int es, input int ec, input int ps, input int pc);
        op_a  = WIDTH'(a);
        op_b  = WIDTH'(b);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            op_a = ~op_a;
            op_b = op_b + 4'd3;
            check_out($sformatf("%s.run%0d", tag, i), 1, 0, ps, pc);
            tick();
        end
        check_out({tag, ".done"}, 0, 1, es, ec);
        tick();
        check_out({tag, ".idle"}, 0, 0, es, ec);
    endtask

    initial begin
        int done_cnt;
        int last_done;

        rst_n = 1'b0;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        tick();
        tick();
        check_out("reset", 0, 0, 0, 0);
        rst_n = 1'b1;
        tick();
        tick();
        check_out("idle_hold", 0, 0, 0, 0);

        run_op("add7_9",   7,  9,  0, 1, 0, 0);
        run_op("add15_15", 15, 15, 14, 1, 0, 1);
        run_op("add3_4",   3,  4,  7, 0, 14, 1);

        // Start and operand activity mid-RUN must be ignored.
        op_a = 4'd5; op_b = 4'd2; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        op_a = 4'd15; start = 1'b1;
        tick();
        start = 1'b0;
        check_out("ignore.e2", 1, 0, 7, 0);
        tick();
        tick();
        check_out("ignore.done", 0, 1, 7, 0);
        tick();
        check_out("ignore.idle1", 0, 0, 7, 0);
        tick();
        check_out("ignore.idle2", 0, 0, 7, 0);

        // Reset lands on edge E2 of 6+6.
        op_a = 4'd6; op_b = 4'd6; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        check_out("abort", 0, 0, 0, 0);
        rst_n = 1'b1;
        tick();
        tick();
        check_out("abort.after", 0, 0, 0, 0);
        run_op("add6_6", 6, 6, 12, 0, 0, 0);

        // Stuck-high start: a new operation every WIDTH+2 cycles.
        op_a = 4'd1; op_b = 4'd1; start = 1'b1;
        done_cnt  = 0;
        last_done = -1;
        for (int k = 0; k < 24; k++) begin
            tick();
            if (done) begin
                check($sformatf("stuck.at%0d", k), k, (last_done < 0) ? WIDTH : last_done + WIDTH + 2);
                check("stuck.sum",   int'(sum),       2);
                check("stuck.carry", int'(carry_out), 0);
                last_done = k;
                done_cnt++;
            end
        end
        start = 1'b0;
        check("stuck.pulses", done_cnt, 4);

        $display("Simulation finished: %0d checks, %0d errors", r_checks, r_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial adder controller for the adder-with-display design.
- Time-shares one 1-bit full-adder cell across WIDTH operand bits, LSB first, under a start/busy/done handshake.
- Holds the registered result (sum, carry_out) stable for the seven-segment display path until the next completed addition.

Parameters:
- WIDTH, 4, operand and sum width in bits; legal range 2..16.
- CNT_W, 4, bit-counter width; must satisfy 2^CNT_W >= WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset; sampled on rising clk.
- start  input  1  request; sampled only in IDLE.
- op_a  input  WIDTH  operand A; captured on the accepted start.
- op_b  input  WIDTH  operand B; captured on the accepted start.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse, high in DONE.
- sum  output  WIDTH  registered result, held between completions.
- carry_out  output  1  registered final carry, held with sum.

Behaviour:
- Reset (rst_n=0 at an edge):
  - state=IDLE; busy=0, done=0, sum=0, carry_out=0.
  - Shift registers, carry flop and counter are cleared.
  - Reset mid-RUN aborts the operation; no done pulse; sum/carry_out read 0.
- States: IDLE, RUN, DONE; 2-bit encoding.
- IDLE:
  - start=1 at edge E0 → RUN.
  - a_sr<=op_a, b_sr<=op_b, c<=0, cnt<=0, busy<=1.
- RUN, one bit per edge:
  - Full-adder inputs are a_sr[0], b_sr[0], c.
  - a_sr and b_sr shift right; s_sr shifts right with the fa sum entering at bit WIDTH-1.
  - c<=fa carry; cnt<=cnt+1.
- RUN exit, at the edge where cnt==WIDTH-1 (edge E_WIDTH):
  - → DONE; sum<={fa_s, s_sr[WIDTH-1:1]}; carry_out<=fa carry.
  - busy<=0, done<=1.
- DONE: lasts exactly one cycle; next edge → IDLE, done<=0.
- Latency:
  - busy is high after edges E0 through E_WIDTH-1.
  - done is high for the single cycle after edge E_WIDTH.
  - Start-to-done is WIDTH+1 edges.
- start is ignored in RUN and DONE; there is no queuing. Back-to-back operations need start high in IDLE, so the minimum period is WIDTH+2 cycles.
- op_a/op_b changes after the accepted start have no effect on the running operation.
- sum/carry_out change only at the RUN→DONE edge or at reset. They are stable at all other times, including during a subsequent RUN.
- Arithmetic: {carry_out,sum} = op_a + op_b, unsigned, modulo 2^(WIDTH+1). No overflow flag beyond carry_out.
- A stuck-high start restarts the operation immediately on each return to IDLE.

Decomposition:
- Package serial_add_pkg:
  - State encoding localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - Defaults WIDTH_DEF=4 and CNT_W_DEF=4.
- One sub-module, full_adder_bit (inputs a, b, cin; outputs s, cout):
  - Built from two half adders (XOR + AND gate primitives) plus an OR.
  - Instantiated once; this is the shared datapath cell being sequenced.
- Everything else (FSM, shift registers, counter, result registers) lives in serial_add_ctrl.

Test Plan (WIDTH=4):
- Reset then idle: after rst_n low for 2 cycles → sum=0, carry_out=0, busy=0, done=0; stays so with start=0.
- op_a=7, op_b=9, start pulse → busy high 4 cycles; done pulses 1 cycle after edge E4; sum=0, carry_out=1.
- op_a=15, op_b=15 → sum=14, carry_out=1. Then op_a=3, op_b=4 → sum=7, carry_out=0, and the previous 14/1 is held until the new DONE edge.
- Start pulses and op_a/op_b changes during RUN (op_a=5, op_b=2 accepted; then op_a=15 and start=1 at E2) → result sum=7, carry_out=0. Exactly one done pulse; no second operation starts.
- rst_n low at edge E2 of op_a=6, op_b=6 → no done pulse; sum=0, carry_out=0, busy=0 next cycle. A new start afterwards with 6+6 yields sum=12, carry_out=0.
- start held high continuously with op_a=1, op_b=1 → done pulses every 6 cycles, sum=2, carry_out=0 each time.
